// File: rtl/tone_scheduler.sv
// tone_scheduler: round-robin sharing of one sample sink among tone sources.
// Plays a granted source for a fixed count of consumed samples, then a gap.
module tone_scheduler #(
  parameter int num_src_p       = 4,
  parameter int width_p         = 12,
  parameter int dwell_samples_p = 4410,
  parameter int gap_samples_p   = 441
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [num_src_p-1:0]         req_i,
  input  logic [num_src_p*width_p-1:0] src_data_i,
  input  logic [num_src_p-1:0]         src_valid_i,
  output logic [num_src_p-1:0]         src_ready_o,
  input  logic                         ready_i,
  output logic [width_p-1:0]           data_o,
  output logic                         valid_o,
  output logic [num_src_p-1:0]         grant_o,
  output logic                         busy_o,
  output logic                         note_done_o
);

  localparam int max_lp = (dwell_samples_p > gap_samples_p)
                        ? dwell_samples_p : gap_samples_p;
  localparam int cmax_lp = (max_lp > 2) ? max_lp : 2;
  localparam int cw_lp = $clog2(cmax_lp);
  localparam int iw_lp = $clog2(num_src_p);
  localparam bit has_gap_lp = (gap_samples_p > 0);
  localparam logic [cw_lp-1:0] dwell_load_lp =
    cw_lp'(dwell_samples_p - 1);
  localparam logic [cw_lp-1:0] gap_load_lp =
    has_gap_lp ? cw_lp'(gap_samples_p - 1) : '0;

  typedef enum logic [1:0] {
    idle_s,
    play_s,
    gap_s,
    arb_s
  } state_e;

  state_e             state_r, state_n;
  logic [iw_lp-1:0]   gidx_r, gidx_n;
  logic [iw_lp-1:0]   ptr_r, ptr_n;
  logic [cw_lp-1:0]   cnt_r, cnt_n;
  logic [iw_lp-1:0]   pick_idx;
  logic               pick_found;
  logic [iw_lp-1:0]   ptr_nxt;
  logic               cons;
  logic [width_p-1:0] src_arr [num_src_p];

  for (genvar k = 0; k < num_src_p; k++) begin : g_src
    assign src_arr[k] = src_data_i[k*width_p +: width_p];
  end

  assign ptr_nxt = (gidx_r == iw_lp'(num_src_p - 1))
                 ? '0 : gidx_r + 1'b1;

  // Cyclic priority scan: first requester at or after the pointer.
  always_comb begin
    int scan;
    logic [iw_lp-1:0] sidx;
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    sidx       = '0;
    for (int i = 0; i < num_src_p; i++) begin
      scan = int'(ptr_r) + i;
      if (scan >= num_src_p) scan = scan - num_src_p;
      sidx = iw_lp'(scan);
      if (!pick_found && req_i[sidx]) begin
        pick_found = 1'b1;
        pick_idx   = sidx;
      end
    end
  end

  // Next-state logic plus the combinational sample path.
  always_comb begin
    state_n     = state_r;
    gidx_n      = gidx_r;
    cnt_n       = cnt_r;
    ptr_n       = ptr_r;
    data_o      = '0;
    valid_o     = 1'b0;
    src_ready_o = '0;
    grant_o     = '0;
    busy_o      = 1'b0;
    note_done_o = 1'b0;
    cons        = 1'b0;
    unique case (state_r)
      idle_s, arb_s: begin
        if (pick_found) begin
          state_n = play_s;
          gidx_n  = pick_idx;
          cnt_n   = dwell_load_lp;
        end else begin
          state_n = idle_s;
        end
      end
      play_s: begin
        busy_o               = 1'b1;
        grant_o[gidx_r]      = 1'b1;
        data_o               = src_arr[gidx_r];
        valid_o              = src_valid_i[gidx_r];
        src_ready_o[gidx_r]  = ready_i;
        cons = src_valid_i[gidx_r] & ready_i;
        if (cons && cnt_r == '0) begin
          note_done_o = 1'b1;
          ptr_n       = ptr_nxt;
          state_n     = has_gap_lp ? gap_s : arb_s;
          cnt_n       = gap_load_lp;
        end else begin
          if (cons) cnt_n = cnt_r - 1'b1;
          if (!req_i[gidx_r]) begin
            ptr_n   = ptr_nxt;
            state_n = has_gap_lp ? gap_s : arb_s;
            cnt_n   = gap_load_lp;
          end
        end
      end
      gap_s: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
        if (ready_i) begin
          if (cnt_r == '0) state_n = arb_s;
          else cnt_n = cnt_r - 1'b1;
        end
      end
      default: state_n = idle_s;
    endcase
  end

  // State, grant, pointer and sample counter registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= idle_s;
      gidx_r  <= '0;
      ptr_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      gidx_r  <= gidx_n;
      ptr_r   <= ptr_n;
      cnt_r   <= cnt_n;
    end
  end

endmodule

// File: doc/tone_scheduler.md
Name: tone_scheduler

Overview:
- Shares one audio output channel among num_src_p tone generators. Each generator presents a ready/valid sample stream.
- Arbitrates pending note requests round-robin and plays the winning source for a fixed number of consumed samples. It then inserts a silence gap and re-arbitrates.
- Sits between the per-note sinusoid generators and the codec/sample sink. The selected generator's address counter advances only when its sample is consumed.

Parameters:
- num_src_p, 4, number of tone sources/requesters (2..16).
- width_p, 12, sample width, two's complement.
- dwell_samples_p, 4410, consumed samples per note (>=1).
- gap_samples_p, 441, consumed silence samples between notes (0 allowed = no gap).

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- req_i  in  num_src_p  level request per source; held while the note is wanted.
- src_data_i  in  num_src_p*width_p  flattened source samples; source k occupies bits [k*width_p +: width_p].
- src_valid_i  in  num_src_p  per-source sample valid.
- src_ready_o  out  num_src_p  per-source ready; at most one bit high.
- ready_i  in  1  downstream sink ready.
- data_o  out  width_p  output sample.
- valid_o  out  1  output sample valid.
- grant_o  out  num_src_p  one-hot current grant; zero when not in PLAY.
- busy_o  out  1  high in PLAY or GAP.
- note_done_o  out  1  one-cycle pulse when a note completes its full dwell.

Behaviour:
- Reset (asynchronous, reset_ni=0):
  - state=IDLE, grant index=0, counter=0.
  - Round-robin pointer set so source 0 has highest priority.
  - Outputs: grant_o=0, busy_o=0, note_done_o=0, src_ready_o=0, data_o=0, valid_o=0.
- Consume event: valid_o & ready_i in the same cycle. All counters count consume events only.
- IDLE:
  - valid_o=0, data_o=0.
  - If req_i!=0, pick the first requesting index at or after the pointer (cyclic), load counter=dwell_samples_p-1, and enter PLAY next cycle. Request-to-PLAY latency is 1 clock.
- PLAY (grant g):
  - data_o = src_data_i[g], valid_o = src_valid_i[g], src_ready_o[g] = ready_i; all other src_ready_o bits are 0. This path is combinational, zero latency.
  - On each consume: if counter==0, the note is complete: pulse note_done_o that cycle, set pointer=g+1 mod num_src_p, and go to GAP (or ARB if gap_samples_p==0). Otherwise decrement the counter.
  - If req_i[g] drops (sampled at the clock edge) before completion, abort: no note_done_o, pointer=g+1, go to GAP/ARB. A consume in that same cycle is still honoured.
- GAP:
  - valid_o=1, data_o=0, src_ready_o=0.
  - Counter loaded with gap_samples_p-1 on entry. Decrement per consume; at a consume with counter==0, go to ARB.
- ARB (one cycle, no output):
  - valid_o=0.
  - Arbitrate as in IDLE → PLAY, or go to IDLE if req_i==0.
  - Merging ARB into IDLE is permitted only if the cycle behaviour is identical.
- grant_o is one-hot of g only in PLAY. busy_o=1 in PLAY and GAP.
- Counter width: $clog2(max(dwell_samples_p, gap_samples_p, 2)). No wrap-around; counters never underflow.
- Source k never sees src_ready_o[k]=1 unless it is granted, so ungranted generators hold their phase.
- Simultaneous events:
  - Completion and a new request in the same cycle: the new request waits for the next ARB.
  - A request asserted during GAP is not served until ARB.
- Reset mid-note: immediate return to IDLE with all outputs at reset values. No note_done_o.

Test Plan:
- Params 4/12/4/2. Reset, then req_i=0010 → PLAY next clock, grant_o=0010. Source 1 data 0x123 appears on data_o. With ready_i=1 there are 4 consumes, then note_done_o pulses, then 2 zero samples with valid_o=1, then IDLE.
- req_i=1111 held → grants cycle 0001, 0010, 0100, 1000, 0001 (round-robin). Each note lasts exactly 4 consumes, separated by 2 gap samples.
- ready_i toggling 1,0,1,0 during PLAY → dwell counts only consumes. 4 consumes take 8 clocks. src_ready_o[g] mirrors ready_i; ungranted src_ready_o bits stay 0.
- src_valid_i[g]=0 for 3 cycles mid-note → valid_o=0 for those cycles and the counter is held. The note still ends after 4 consumes.
- req_i[g] dropped after 2 consumes → no note_done_o, GAP of 2 samples entered. Next arbitration starts at g+1.
- reset_ni pulsed low mid-PLAY, asynchronously between edges → outputs go to zero immediately and state is IDLE. gap_samples_p=0 build: note end goes directly to ARB with no zero samples.
